// File: rtl/bpu_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module      : bpu_perf_monitor
// Description : Eight saturating branch-prediction event counters fed by the
//               CPU debug outputs, read back through a req/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bpu_perf_monitor #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [31:0]      inst_ex,
  input  logic             flush,
  input  logic             stall,
  input  logic             hit,
  input  logic             rd_req,
  input  logic [2:0]       rd_sel,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data,
  output logic [7:0]       ovf
);

  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
  localparam logic [6:0]       C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0]       C_OP_JAL    = 7'b1101111;
  localparam logic [6:0]       C_OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic [CNT_W-1:0] r_cnt [8];
  logic [7:0]       r_ovf;
  logic [7:0]       w_inc;
  logic             r_flush_q;
  logic [6:0]       w_opcode;

  assign w_opcode = inst_ex[6:0];

  // Events 3/4/5/7 are stall-gated so a frozen EX/IF register is counted once.
  always_comb begin
    w_inc = '0;
    if (en) begin
      w_inc[0] = 1'b1;
      w_inc[1] = !stall;
      w_inc[2] = stall;
      w_inc[3] = !stall && (w_opcode == C_OP_BRANCH);
      w_inc[4] = !stall && (w_opcode == C_OP_JAL);
      w_inc[5] = !stall && (w_opcode == C_OP_JALR);
      w_inc[6] = flush && !r_flush_q;
      w_inc[7] = hit && !stall;
    end
  end

  // Edge history runs independently of en and clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flush_q <= 1'b0;
    end else begin
      r_flush_q <= flush;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= '0;
      end
      r_ovf <= '0;
    end else if (clr) begin
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_inc[i]) begin
          if (r_cnt[i] == C_CNT_MAX) begin
            r_ovf[i] <= 1'b1;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // WAIT_LOW forces a request low phase before the next capture.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (rd_req) begin
          w_accept     = 1'b1;
          w_state_next = ACK;
        end
      end
      ACK:      w_state_next = WAIT_LOW;
      WAIT_LOW: if (!rd_req) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (w_accept) begin
      rd_data <= r_cnt[rd_sel];
    end
  end

  assign rd_ack = (r_state == ACK);
  assign ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bpu_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpu_perf_monitor
// Description : Directed and random checks of two monitor instances (32/8 bit)
//               against an event-rule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpu_perf_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, clr = 1'b0, flush = 1'b0, stall = 1'b0, hit = 1'b0;
  logic        rd_req = 1'b0;
  logic [2:0]  rd_sel = 3'd0;
  logic [31:0] inst_ex = 32'h0000_0013;

  logic        rd_ack32, rd_ack8;
  logic [31:0] rd_data32;
  logic [7:0]  rd_data8;
  logic [7:0]  ovf32, ovf8;

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint      m32 [8];
  longint      m8  [8];
  logic [7:0]  movf32, movf8;
  logic [31:0] exp_data32;
  logic [7:0]  exp_data8;
  bit          exp_ack;
  bit          armed;
  bit          prev_flush;

  localparam longint C_MAX32 = 64'hFFFF_FFFF;
  localparam longint C_MAX8  = 64'd255;

  bpu_perf_monitor #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .inst_ex(inst_ex),
    .flush(flush), .stall(stall), .hit(hit), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_ack(rd_ack32), .rd_data(rd_data32), .ovf(ovf32)
  );

  bpu_perf_monitor #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .inst_ex(inst_ex),
    .flush(flush), .stall(stall), .hit(hit), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_ack(rd_ack8), .rd_data(rd_data8), .ovf(ovf8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m32[i] = 0;
      m8[i]  = 0;
    end
    movf32 = '0; movf8 = '0;
    exp_data32 = '0; exp_data8 = '0;
    exp_ack = 1'b0; armed = 1'b1; prev_flush = 1'b0;
  endtask

  // Applies the event rules for one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    logic [7:0] ev;
    logic [6:0] op;
    if (!rst) return;
    op    = inst_ex[6:0];
    ev[0] = en;
    ev[1] = en && !stall;
    ev[2] = en && stall;
    ev[3] = en && !stall && (op == 7'h63);
    ev[4] = en && !stall && (op == 7'h6F);
    ev[5] = en && !stall && (op == 7'h67);
    ev[6] = en && flush && !prev_flush;
    ev[7] = en && hit && !stall;
    if (armed && rd_req) begin
      exp_data32 = 32'(m32[rd_sel]);
      exp_data8  = 8'(m8[rd_sel]);
      armed      = 1'b0;
      exp_ack    = 1'b1;
    end else if (exp_ack) begin
      exp_ack = 1'b0;
    end else if (!armed && !rd_req) begin
      armed = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      if (clr) begin
        m32[i] = 0; m8[i] = 0;
      end else if (ev[i]) begin
        if (m32[i] == C_MAX32) movf32[i] = 1'b1; else m32[i]++;
        if (m8[i] == C_MAX8)   movf8[i]  = 1'b1; else m8[i]++;
      end
    end
    if (clr) begin
      movf32 = '0; movf8 = '0;
    end
    prev_flush = flush;
  endtask

  task automatic check_outputs();
    chk("ack32", {31'b0, rd_ack32}, {31'b0, exp_ack});
    chk("ack8", {31'b0, rd_ack8}, {31'b0, exp_ack});
    chk("data32", rd_data32, exp_data32);
    chk("data8", {24'b0, rd_data8}, {24'b0, exp_data8});
    chk("ovf32", {24'b0, ovf32}, {24'b0, movf32});
    chk("ovf8", {24'b0, ovf8}, {24'b0, movf8});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    en = 0; clr = 0; flush = 0; stall = 0; hit = 0; rd_req = 0; rd_sel = 0;
    inst_ex = 32'h0000_0013;
    rst = 0;
    #1;
    model_reset();
    check_outputs();
    step();
    step();
    rst = 1;
  endtask

  task automatic read_cnt(input logic [2:0] sel, input logic [31:0] e32, input logic [7:0] e8);
    int n;
    rd_sel = sel;
    rd_req = 1;
    n = 0;
    do begin
      step();
      n++;
    end while (!rd_ack32 && n < 5);
    chk("rd_timeout", {31'b0, rd_ack32}, 32'd1);
    chk("rd_val32", rd_data32, e32);
    chk("rd_val8", {24'b0, rd_data8}, {24'b0, e8});
    rd_req = 0;
    step();
    step();
  endtask

  initial begin
    model_reset();

    // 1: free-running cycles
    do_reset();
    en = 1;
    repeat (10) step();
    en = 0;
    read_cnt(3'd0, 32'd10, 8'd10);
    read_cnt(3'd1, 32'd10, 8'd10);
    read_cnt(3'd2, 32'd0, 8'd0);

    // 2: conditional branch with a stall bubble
    do_reset();
    en = 1; inst_ex = 32'h00B5_0463;
    step();
    stall = 1; step();
    stall = 0; step();
    en = 0; inst_ex = 32'h0000_0013;
    read_cnt(3'd3, 32'd2, 8'd2);
    read_cnt(3'd2, 32'd1, 8'd1);

    // 3: flush rising edges only
    do_reset();
    en = 1;
    flush = 1; repeat (3) step();
    flush = 0; step();
    flush = 1; step();
    flush = 0; en = 0;
    read_cnt(3'd6, 32'd2, 8'd2);

    // 4: saturation and clear
    do_reset();
    en = 1;
    repeat (300) step();
    en = 0;
    chk("t4_ovf8_0", {31'b0, ovf8[0]}, 32'd1);
    read_cnt(3'd0, 32'd300, 8'd255);
    clr = 1; step();
    clr = 0;
    chk("t4_ovf8_clr", {24'b0, ovf8}, 32'd0);
    read_cnt(3'd0, 32'd0, 8'd0);

    // 5: JAL count, single ack while request held
    do_reset();
    en = 1; inst_ex = 32'h0080_006F;
    repeat (5) step();
    en = 0; inst_ex = 32'h0000_0013;
    rd_sel = 3'd4; rd_req = 1;
    step();
    chk("t5_ack", {31'b0, rd_ack32}, 32'd1);
    chk("t5_data", rd_data32, 32'd5);
    rd_sel = 3'd0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5_no_reack", {31'b0, rd_ack32}, 32'd0);
    end
    rd_req = 0; step(); step();

    // 6: asynchronous reset in the middle of an ack
    en = 1; rd_sel = 3'd0; rd_req = 1;
    step();
    chk("t6_ack_before", {31'b0, rd_ack32}, 32'd1);
    rst = 0;
    #1;
    model_reset();
    chk("t6_ack_async", {31'b0, rd_ack32}, 32'd0);
    chk("t6_data_rst", rd_data32, 32'd0);
    step();
    rst = 1;
    step();
    chk("t6_fresh_ack", {31'b0, rd_ack32}, 32'd1);
    chk("t6_fresh_data", rd_data32, 32'd0);
    rd_req = 0; step(); step();

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      en    = ($urandom_range(0, 9) != 0);
      clr   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) < 3);
      stall = ($urandom_range(0, 3) == 0);
      hit   = $urandom_range(0, 1) == 1;
      rd_req = ($urandom_range(0, 9) < 6);
      rd_sel = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: inst_ex = 32'h00B5_0463;
        1: inst_ex = 32'h0080_006F;
        2: inst_ex = 32'h0000_80E7;
        3: inst_ex = 32'h0000_0013;
        default: inst_ex = $urandom;
      endcase
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
